// File: rtl/lsu_mem_port.sv
// Load/store unit driving a single-cycle word memory port.
// Sub-word stores use read-modify-write; loads are sign/zero-extended per lane.
module lsu_mem_port #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        req_err;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  a,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {a, 3'b000});
    h = 16'(word >> {a[1], 4'b0000});
    case (size)
      2'b00:   load_extend = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  a);
    logic [4:0]  sh;
    logic [31:0] m;
    sh = (size == 2'b00) ? {a, 3'b000} : {a[1], 4'b0000};
    m  = ((size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merge_lane = (word & ~m) | ((wd << sh) & m);
  endfunction

  // Rejected before any memory traffic: reserved size, misalignment, out of range
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr[31:2] >= 30'(MEM_WORDS)) req_err = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wbuf_d     = wbuf_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          if (req_err) begin
            rdata_d = 32'h0;
            error_d = 1'b1;
            state_d = RESP;
          end else if (req_write && req_size == 2'b10) begin
            wbuf_d  = req_wdata;
            state_d = WRITE;
          end else begin
            if (req_write) wbuf_d = req_wdata;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (write_q) begin
          wbuf_d  = merge_lane(mem_read_data, wbuf_q, size_q, addr_q[1:0]);
          state_d = WRITE;
        end else begin
          rdata_d = load_extend(mem_read_data, size_q, addr_q[1:0], unsigned_q);
          error_d = 1'b0;
          state_d = RESP;
        end
      end
      WRITE: begin
        rdata_d = 32'h0;
        error_d = 1'b0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= 32'h0;
      wbuf_q     <= 32'h0;
      rdata_q    <= 32'h0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wbuf_q     <= wbuf_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign mem_write_en   = (state_q == WRITE);
  assign mem_addr       = {addr_q[31:2], 2'b00};
  assign mem_write_data = wbuf_q;
  assign resp_rdata     = rdata_q;
  assign resp_error     = error_q;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit that initiates accesses on the single-cycle data memory port: write enable, byte address, write data, with asynchronous read data returned in the same cycle. It accepts one byte, halfword or word load/store request at a time from the processor core over a valid/ready handshake and returns a one-cycle response. Sub-word stores are performed as read-modify-write, because the memory writes whole words only. Loads are sign- or zero-extended, and misaligned, reserved-size or out-of-range requests are flagged.

## Interface
- MEM_WORDS, 64, number of 32-bit words in the attached memory; word index ≥ MEM_WORDS is out of range
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  LSU can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0])
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  valid with resp_valid; request was rejected
- mem_write_en  out  1  memory write strobe
- mem_addr  out  32  word-aligned byte address {addr[31:2],2'b00}
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  asynchronous read of mem_addr

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch the request and check for errors:
  - error: size 11; halfword with addr[0]=1; word with addr[1:0]≠0; or addr[31:2] ≥ MEM_WORDS. On error go to RESP with error set. No memory write occurs.
  - word store: load wbuf=req_wdata and go to WRITE.
  - load or sub-word store: go to ACCESS.
- ACCESS: mem_addr is driven and mem_write_en=0. Sample mem_read_data.
  - Load: extract the lane, extend it to 32 bits, store it in the response register, then go to RESP.
  - Sub-word store: set wbuf = read word with only the target lane replaced, then go to WRITE.
- WRITE: mem_write_en=1 and mem_write_data=wbuf. The memory updates on this cycle's closing edge. Then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- Lanes are little-endian:
  - byte k=addr[1:0] occupies bits [8k+7:8k];
  - halfword h=addr[1] occupies bits [16h+15:16h].
- Sign extension replicates bit 7 (byte) or bit 15 (halfword). Word loads are returned unmodified.
- Store data bits above the access size are ignored.
- mem_write_en is decoded from state only (high iff WRITE), never from inputs.

## Timing
- Requests are accepted at the edge ending cycle T where req_valid & req_ready. resp_valid is high in:
  - error: T+1
  - load: T+2
  - word store: T+2 (write in T+1)
  - sub-word store: T+3 (read in T+1, write in T+2)
- req_ready is low from T+1 until the cycle after RESP. req_valid/req_addr are ignored outside IDLE.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_write_en=0, mem_addr=0, mem_write_data=0.
- mem_addr and mem_write_data hold their latched values between requests. resp_rdata holds its value until the next response.
- Reset asserted mid-operation (any state) forces IDLE immediately, without a clock edge. mem_write_en drops at once. Any pending write or response is discarded.
- Reset deassertion is synchronous-safe: the first request can be accepted on the first edge after release.

## Test plan
- Reset: assert reset_n=0 mid-stream → all outputs 0 and req_ready=1 asynchronously. Release, then present lw 0x0 → resp_valid at T+2.
- Word round trip: sw 0x8, 0xDEADBEEF → mem_write_en only in T+1, mem_addr=0x8, resp_valid at T+2 with rdata 0. Then lw 0x8 → rdata 0xDEADBEEF at T+2.
- Byte store and loads: sb 0x9, 0x123456AA onto 0xDEADBEEF → ACCESS in T+1, write of 0xDEADAAEF in T+2, resp at T+3. Then:
  - lb 0x9 → 0xFFFFFFAA
  - lbu 0x9 → 0x000000AA
  - lbu 0xB → 0x000000DE
- Halfword: sh 0xA, 0xFFFF1234 → word 0x1234AAEF. Then:
  - lh 0xA → 0x00001234
  - lh 0x8 → 0xFFFFAAEF
  - lhu 0x8 → 0x0000AAEF
- Errors: each of the following gives resp_error=1 and resp_rdata=0 at T+1, with mem_write_en never high; a following lw 0x8 still returns 0x1234AAEF.
  - lw 0x6
  - lh 0x3
  - size 11
  - sw 0x100 with MEM_WORDS=64
- Reset during WRITE of sb 0x8 → mem_write_en falls without a clock edge, memory word is unchanged, no resp_valid, and req_ready=1.
